// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes, debounces and edge-detects one push-button, with optional auto-repeat.
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   key           raw asynchronous button level
//   repeat_en     1 enables auto-repeat while held
//   pressed       debounced level, 1 while held
//   press_pulse   one cycle on debounced 0->1
//   release_pulse one cycle on debounced 1->0
//   repeat_pulse  one cycle per auto-repeat
//   event_pulse   press_pulse | repeat_pulse
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    input  logic repeat_en,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic event_pulse
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic          n;
    logic          s1_q, s2_q;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          rep_q, rep_d;
    logic          evt_q, evt_d;
    logic [CW-1:0] db_q, db_d;
    logic [RW-1:0] rc_q, rc_d;
    state_t        st_q, st_d;
    logic          db_hit, flip, rise, fall;

    assign n = (ACTIVE_LOW != 0) ? ~key : key;

    always_comb begin
        db_hit    = db_q == CW'(DEBOUNCE_CYCLES - 1);
        flip      = (s2_q != pressed_q) && db_hit;
        rise      = flip && !pressed_q;
        fall      = flip && pressed_q;
        db_d      = (s2_q == pressed_q || db_hit) ? '0 : db_q + CW'(1);
        pressed_d = pressed_q ^ flip;
        press_d   = rise;
        rel_d     = fall;
    end

    // Release (or repeat_en dropping) wins over a repeat due on the same edge.
    always_comb begin
        st_d  = st_q;
        rc_d  = rc_q + RW'(1);
        rep_d = 1'b0;
        case (st_q)
            IDLE: begin
                rc_d = '0;
                if (rise && repeat_en) st_d = DELAY;
            end
            DELAY: begin
                if (fall || !repeat_en) begin
                    st_d = IDLE;
                    rc_d = '0;
                end else if (rc_q == RW'(REPEAT_DELAY - 1)) begin
                    st_d  = REPEAT;
                    rc_d  = '0;
                    rep_d = 1'b1;
                end
            end
            REPEAT: begin
                if (fall || !repeat_en) begin
                    st_d = IDLE;
                    rc_d = '0;
                end else if (rc_q == RW'(REPEAT_PERIOD - 1)) begin
                    rc_d  = '0;
                    rep_d = 1'b1;
                end
            end
            default: begin
                st_d = IDLE;
                rc_d = '0;
            end
        endcase
        evt_d = rise | rep_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
            rep_q     <= 1'b0;
            evt_q     <= 1'b0;
            db_q      <= '0;
            rc_q      <= '0;
            st_q      <= IDLE;
        end else begin
            s1_q      <= n;
            s2_q      <= s1_q;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
            rep_q     <= rep_d;
            evt_q     <= evt_d;
            db_q      <= db_d;
            rc_q      <= rc_d;
            st_q      <= st_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign repeat_pulse  = rep_q;
    assign event_pulse   = evt_q;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench for key_conditioner with directed press/release/repeat scenarios.
module tb_key_conditioner;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic key = 1'b1;
    logic repeat_en = 1'b0;
    logic pressed, press_pulse, release_pulse, repeat_pulse, event_pulse;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         c;
        logic [4:0] v;
    } exp_t;
    exp_t q[$];

    localparam logic [4:0] V_PRESS = 5'b11001;
    localparam logic [4:0] V_REL   = 5'b00100;
    localparam logic [4:0] V_REP   = 5'b10011;

    key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key(key),
        .repeat_en(repeat_en),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse),
        .event_pulse(event_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wire [4:0] outs = {pressed, press_pulse, release_pulse, repeat_pulse, event_pulse};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [4:0] v);
        exp_t e;
        e.c = c;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Press the key, hold it until rel_off cycles after the press pulse, then release.
    task automatic press_hold(input int rel_off, input logic rep);
        int p, r;
        p = cyc + 6;
        r = p + rel_off + 6;
        repeat_en = rep;
        key = 1'b0;
        push(p, V_PRESS);
        if (rep) for (int t = p + 10; t < r; t += 3) push(t, V_REP);
        push(r, V_REL);
        tick(6 + rel_off);
        key = 1'b1;
        tick(15);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            while (q.size() != 0 && q[0].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse: got nothing expected %b at cycle %0d", q[0].v, q[0].c);
                void'(q.pop_front());
            end
            if (press_pulse | release_pulse | repeat_pulse | event_pulse) begin
                checks++;
                if (q.size() == 0 || q[0].c != cyc) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got %b expected none at cycle %0d", outs, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (outs !== e.v) begin
                        errors++;
                        $display("FAIL pulse_value: got %b expected %b at cycle %0d", outs, e.v, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        int p, r;
        tick(3);
        chk("reset_outputs", outs, 5'b0);
        reset = 1'b1;
        tick(20);
        chk("idle_outputs", outs, 5'b0);

        p = cyc + 6;
        key = 1'b0;
        push(p, V_PRESS);
        tick(15);
        chk("pressed_level", outs, 5'b10000);
        push(cyc + 6, V_REL);
        key = 1'b1;
        tick(15);

        key = 1'b0;
        tick(3);
        key = 1'b1;
        tick(10);
        chk("glitch_rejected", outs, 5'b0);

        press_hold(10, 1'b0);
        press_hold(31, 1'b1);
        press_hold(3, 1'b1);
        press_hold(30, 1'b0);

        p = cyc + 6;
        repeat_en = 1'b1;
        key = 1'b0;
        push(p, V_PRESS);
        push(p + 10, V_REP);
        push(p + 13, V_REP);
        tick(20);
        repeat_en = 1'b0;
        tick(6);
        repeat_en = 1'b1;
        tick(6);
        chk("held_no_repeat", outs, 5'b10000);
        push(cyc + 6, V_REL);
        key = 1'b1;
        tick(15);

        p = cyc + 6;
        key = 1'b0;
        push(p, V_PRESS);
        push(p + 10, V_REP);
        push(p + 13, V_REP);
        tick(20);
        chk("pre_reset_held", outs, 5'b10000);
        #2 reset = 1'b0;
        #1 chk("async_reset", outs, 5'b0);
        tick(3);
        chk("in_reset", outs, 5'b0);
        reset = 1'b1;
        p = cyc + 6;
        r = cyc + 30;
        push(p, V_PRESS);
        for (int t = p + 10; t < r; t += 3) push(t, V_REP);
        push(r, V_REL);
        tick(24);
        key = 1'b1;
        tick(15);
        chk("final_idle", outs, 5'b0);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
